// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: control, flag, LUT-write and PC bundle for the pc_ctrl stage.
// master drives the requests and LUT writes; slave is the pc_ctrl side.
interface pc_ctrl_if #(
  parameter int PC_W  = 10,
  parameter int LUT_W = 4
);
  logic             start;
  logic             stall;
  logic             branch_op;
  logic             notequal;
  logic             lessthan;
  logic [LUT_W-1:0] target_idx;
  logic             halt_req;
  logic             lut_we;
  logic [LUT_W-1:0] lut_waddr;
  logic [PC_W-1:0]  lut_wdata;
  logic [PC_W-1:0]  prog_ctr;
  logic             running;
  logic             done;

  modport master (
    output start, stall, branch_op,
    output notequal, lessthan, target_idx,
    output halt_req,
    output lut_we, lut_waddr, lut_wdata,
    input  prog_ctr, running, done
  );

  modport slave (
    input  start, stall, branch_op,
    input  notequal, lessthan, target_idx,
    input  halt_req,
    input  lut_we, lut_waddr, lut_wdata,
    output prog_ctr, running, done
  );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: program counter, branch-target LUT and IDLE/RUN/HALT sequencing.
// Optional: PC_WRAP_HALT_EN halts instead of wrapping at the top address.
module pc_ctrl #(
  parameter int PC_W  = 10,
  parameter int LUT_W = 4
) (
  input logic     clk,
  input logic     rst_n,
  pc_ctrl_if.slave bus
);

  localparam int DEPTH = 1 << LUT_W;
  localparam logic [PC_W-1:0] PC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic            start_q;
  logic [PC_W-1:0] lut_q [DEPTH];

  logic            launch;
  logic            taken;
  logic [PC_W-1:0] tgt;
  logic            at_top;

  assign launch = start_q & ~bus.start;
  assign taken  = bus.branch_op
                & (bus.notequal | bus.lessthan);
  assign tgt    = lut_q[bus.target_idx];
  assign at_top = (pc_q == PC_MAX);

  assign bus.prog_ctr = pc_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;

  // state, PC, status flags and start edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
      start_q   <= bus.start;
    end
  end

  // branch target table; same-cycle read sees the old entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else if (bus.lut_we) begin
      lut_q[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

  // next state: start restarts, stall freezes, halt beats branch
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (launch) state_d = RUN;
      end
      RUN: begin
        if (bus.start) begin
          state_d = IDLE;
        end else if (bus.stall) begin
          state_d = RUN;
        end else if (bus.halt_req) begin
          state_d = HALT;
        end else if (taken) begin
          state_d = RUN;
`ifdef PC_WRAP_HALT_EN
        end else if (at_top) begin
          state_d = HALT;
`endif
        end else begin
          state_d = RUN;
        end
      end
      HALT: begin
        if (bus.start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // next PC and registered decodes of the next state
  always_comb begin
    pc_d      = pc_q;
    running_d = (state_d == RUN);
    done_d    = (state_d == HALT);
    unique case (state_q)
      IDLE: begin
        pc_d = '0;
      end
      RUN: begin
        if (bus.start) begin
          pc_d = '0;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.halt_req) begin
          pc_d = pc_q;
        end else if (taken) begin
          pc_d = tgt;
        end else begin
`ifdef PC_WRAP_HALT_EN
          pc_d = at_top ? pc_q : pc_q + PC_W'(1);
`else
          pc_d = pc_q + PC_W'(1);
`endif
        end
      end
      HALT: begin
        if (bus.start) pc_d = '0;
      end
      default: pc_d = '0;
    endcase
  end

`ifndef PC_WRAP_HALT_EN
  logic unused_top;
  assign unused_top = at_top;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed vectors for pc_ctrl with hand-computed PC/status values.
// Build with +define+PC_WRAP_HALT_EN to check the halt-at-top variant.
module tb_pc_ctrl;

  localparam int PC_W  = 10;
  localparam int LUT_W = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  pc_ctrl_if #(.PC_W(PC_W), .LUT_W(LUT_W)) bus ();

  pc_ctrl #(.PC_W(PC_W), .LUT_W(LUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lut_wr(input logic [LUT_W-1:0] a,
                        input logic [PC_W-1:0] d);
    bus.lut_we    = 1'b1;
    bus.lut_waddr = a;
    bus.lut_wdata = d;
    tick();
    bus.lut_we    = 1'b0;
  endtask

  task automatic br(input logic [LUT_W-1:0] idx,
                    input logic ne,
                    input logic lt);
    bus.branch_op  = 1'b1;
    bus.target_idx = idx;
    bus.notequal   = ne;
    bus.lessthan   = lt;
  endtask

  task automatic br_off();
    bus.branch_op = 1'b0;
    bus.notequal  = 1'b0;
    bus.lessthan  = 1'b0;
  endtask

  task automatic relaunch();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
  endtask

  initial begin
    n_chk          = 0;
    n_pass         = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.stall      = 1'b0;
    bus.branch_op  = 1'b0;
    bus.notequal   = 1'b0;
    bus.lessthan   = 1'b0;
    bus.target_idx = '0;
    bus.halt_req   = 1'b0;
    bus.lut_we     = 1'b0;
    bus.lut_waddr  = '0;
    bus.lut_wdata  = '0;

    #12;
    check("rst_pc", 32'(bus.prog_ctr), 32'h0);
    check("rst_run", 32'(bus.running), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    rst_n = 1'b1;

    lut_wr(4'd3, 10'h120);
    lut_wr(4'd2, 10'h010);
    lut_wr(4'd5, 10'h040);
    lut_wr(4'd6, 10'h3FC);
    lut_wr(4'd7, 10'h055);
    check("idle_pc", 32'(bus.prog_ctr), 32'h0);
    check("idle_run", 32'(bus.running), 32'h0);

    bus.start = 1'b1;
    repeat (3) tick();
    check("start_hi_idle", 32'(bus.running), 32'h0);
    bus.start = 1'b0;
    tick();
    check("launch_run", 32'(bus.running), 32'h1);
    check("launch_pc", 32'(bus.prog_ctr), 32'h0);
    repeat (5) tick();
    check("seq_pc5", 32'(bus.prog_ctr), 32'h5);
    repeat (2) tick();
    check("seq_pc7", 32'(bus.prog_ctr), 32'h7);

    br(4'd3, 1'b1, 1'b0);
    tick();
    check("br_ne_taken", 32'(bus.prog_ctr), 32'h120);
    br(4'd3, 1'b0, 1'b0);
    tick();
    check("br_not_taken", 32'(bus.prog_ctr), 32'h121);
    br_off();
    bus.notequal = 1'b1;
    bus.lessthan = 1'b1;
    bus.target_idx = 4'd3;
    tick();
    check("flags_no_op", 32'(bus.prog_ctr), 32'h122);
    br(4'd5, 1'b0, 1'b1);
    tick();
    check("br_lt_taken", 32'(bus.prog_ctr), 32'h040);

    bus.halt_req = 1'b1;
    bus.stall    = 1'b1;
    tick();
    check("stall_pc", 32'(bus.prog_ctr), 32'h040);
    check("stall_run", 32'(bus.running), 32'h1);
    check("stall_done", 32'(bus.done), 32'h0);
    bus.stall = 1'b0;
    tick();
    check("halt_pc", 32'(bus.prog_ctr), 32'h040);
    check("halt_done", 32'(bus.done), 32'h1);
    check("halt_run", 32'(bus.running), 32'h0);
    bus.halt_req = 1'b0;
    br_off();
    tick();
    check("halt_hold_pc", 32'(bus.prog_ctr), 32'h040);
    check("halt_hold_done", 32'(bus.done), 32'h1);
    bus.start = 1'b1;
    tick();
    check("halt_exit_done", 32'(bus.done), 32'h0);
    check("halt_exit_pc", 32'(bus.prog_ctr), 32'h0);
    bus.start = 1'b0;
    tick();
    check("relaunch_run", 32'(bus.running), 32'h1);

    br(4'd2, 1'b1, 1'b0);
    bus.lut_we    = 1'b1;
    bus.lut_waddr = 4'd2;
    bus.lut_wdata = 10'h200;
    tick();
    bus.lut_we = 1'b0;
    check("lut_old_val", 32'(bus.prog_ctr), 32'h010);
    tick();
    check("lut_new_val", 32'(bus.prog_ctr), 32'h200);
    br_off();

    bus.start = 1'b1;
    tick();
    check("restart_pc", 32'(bus.prog_ctr), 32'h0);
    check("restart_run", 32'(bus.running), 32'h0);
    bus.start = 1'b0;
    tick();
    check("restart_launch", 32'(bus.running), 32'h1);

    br(4'd6, 1'b1, 1'b0);
    tick();
    br_off();
    check("to_3fc", 32'(bus.prog_ctr), 32'h3FC);
    repeat (3) tick();
    check("at_3ff", 32'(bus.prog_ctr), 32'h3FF);
    tick();
`ifdef PC_WRAP_HALT_EN
    check("wrap_pc", 32'(bus.prog_ctr), 32'h3FF);
    check("wrap_done", 32'(bus.done), 32'h1);
    check("wrap_run", 32'(bus.running), 32'h0);
`else
    check("wrap_pc", 32'(bus.prog_ctr), 32'h000);
    check("wrap_run", 32'(bus.running), 32'h1);
    check("wrap_done", 32'(bus.done), 32'h0);
`endif

    relaunch();
    br(4'd7, 1'b0, 1'b1);
    tick();
    br_off();
    check("to_055", 32'(bus.prog_ctr), 32'h055);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc", 32'(bus.prog_ctr), 32'h0);
    check("arst_run", 32'(bus.running), 32'h0);
    check("arst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    relaunch();
    check("post_rst_run", 32'(bus.running), 32'h1);
    tick();
    check("post_rst_pc1", 32'(bus.prog_ctr), 32'h1);
    br(4'd3, 1'b1, 1'b0);
    tick();
    br_off();
    check("lut_cleared", 32'(bus.prog_ctr), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Program-counter and branch-resolution stage, directly downstream of the ALU.
- Consumes the ALU's combinational notequal/lessthan flags plus decoder controls, and produces the next instruction address for instruction ROM.
- Resolves branch targets through a small writable target lookup table (LUT) indexed by the instruction's immediate field.
- Owns the run/halt sequencing that brackets each program.

Parameters:
- PC_W, 10: width of program counter; address space 2^PC_W.
- LUT_W, 4: width of branch target index; LUT depth 2^LUT_W entries of PC_W bits.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level request from bench; program launches on its falling edge
- stall  in  1  hold PC this cycle (memory busy)
- branch_op  in  1  current instruction is bneq or blt
- notequal  in  1  ALU branch flag
- lessthan  in  1  ALU branch flag
- target_idx  in  LUT_W  LUT index from instruction immediate
- halt_req  in  1  decoder sees halt instruction
- lut_we  in  1  LUT write enable
- lut_waddr  in  LUT_W  LUT write index
- lut_wdata  in  PC_W  LUT write data (absolute target address)
- prog_ctr  out  PC_W  current instruction address
- running  out  1  high in RUN state
- done  out  1  high in HALT state

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (async, rst_n=0):
  - state=IDLE, prog_ctr=0, running=0, done=0.
  - start_q=0.
  - All LUT entries=0.
- start_q is a 1-cycle registered copy of start. A launch edge is start_q=1 and start=0.
- States: IDLE, RUN, HALT. running and done are registered decodes of the state (RUN and HALT respectively).
- IDLE:
  - prog_ctr held at 0.
  - On a launch edge, go to RUN. First fetch address is 0, presented from the cycle the state enters RUN.
- RUN, evaluated each cycle in priority order:
  1. start=1: go to IDLE, prog_ctr<=0 (restart). Overrides everything below.
  2. stall=1: hold prog_ctr and state. halt_req and branch are ignored this cycle.
  3. halt_req=1: go to HALT, prog_ctr held. Halt beats branch if both are asserted.
  4. taken = branch_op & (notequal | lessthan): prog_ctr <= LUT[target_idx].
  5. Otherwise prog_ctr <= prog_ctr + 1, modulo 2^PC_W (2^PC_W-1 wraps to 0).
- Flag qualification:
  - Flags are sampled only when branch_op=1.
  - notequal/lessthan asserted without branch_op do not affect the PC.
- Latency: decisions are combinational on the current cycle's inputs. The new prog_ctr is visible after the next rising clk edge (1-cycle next-PC latency).
- HALT:
  - done=1, prog_ctr frozen.
  - start=1: go to IDLE, prog_ctr<=0, done<=0 on that edge.
  - A subsequent launch edge re-enters RUN.
- LUT:
  - Registered array. Writes are accepted in any state when lut_we=1.
  - A read of the same index in the same cycle as a write returns the old entry; the new value is used from the next cycle.
  - Writes during RUN are legal.
- Reset mid-operation: immediately returns to the reset values listed above regardless of state. No partial update survives.

Optional Feature:
- Macro PC_WRAP_HALT_EN.
- Defined: in RUN, if the sequential increment path is selected while prog_ctr=2^PC_W-1, go to HALT (done=1) with prog_ctr held at 2^PC_W-1 instead of wrapping. Branch, halt, stall and start paths are unchanged.
- Undefined: prog_ctr wraps to 0 and stays in RUN.

Test Plan:
- Launch: reset, start=1 for 3 cycles, then 0 -> prog_ctr=0, running=1 the following cycle; 5 unstalled cycles later prog_ctr=5.
- Taken branch: LUT[3]=0x120 written in IDLE; in RUN at prog_ctr=7, branch_op=1, notequal=1, target_idx=3 -> next prog_ctr=0x120. Same with notequal=0, lessthan=0 -> prog_ctr=8.
- Priority: halt_req=1 and taken branch in the same cycle at prog_ctr=0x40 -> done=1, prog_ctr stays 0x40. With stall=1 in the same cycle instead -> prog_ctr stays 0x40, state RUN.
- LUT write/read collision: LUT[2]=0x010, then in one cycle write LUT[2]=0x200 while branching via idx 2 -> prog_ctr=0x010. The next branch via idx 2 -> 0x200.
- Wrap: run to prog_ctr=0x3FF (PC_W=10) -> next 0x000 and running=1 without PC_WRAP_HALT_EN; with it, done=1 and prog_ctr=0x3FF.
- Async reset mid-RUN at prog_ctr=0x55, between clock edges -> prog_ctr=0, running=0, done=0 immediately; LUT reads return 0 after release.
